// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect constants.
//   NUMBER_MASTER / ADDR_WIDTH / DATA_WIDTH : default interconnect geometry
//   BRESP_OKAY / BRESP_SLVERR               : write response codes
package axil_pkg;

    localparam int NUMBER_MASTER = 2;
    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_chan_buf.sv
// One-entry valid/ready holding register for an AXI-Lite request channel.
//   aclk, aresetn : clock, async active-low reset
//   load          : upstream handshake this cycle (only asserted while empty)
//   data_in       : payload captured on load
//   drain         : downstream ready; empties the entry when full
//   full          : entry holds a payload (drives the downstream valid)
//   data          : held payload; keeps its last value once drained
module axil_chan_buf #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                data <= data_in;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_mux_wr.sv
// AXI-Lite write-channel mux sitting behind the round-robin write arbiter.
// Routes the granted master's AW and W through one-entry buffers to the
// slave and returns the slave's B response to that master only.
//   aclk, aresetn     : clock, async active-low reset
//   grant_wr          : one-hot grant from the arbiter (sampled in IDLE only)
//   m_axil_aw*/w*/b*  : per-master ports, flattened master-major
//   s_axil_aw*/w*/b*  : single slave port
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a grant; every ready/valid toward masters is low
//   XFER  | accepting AW and W once each from master sel, draining buffers
//   RESP  | both requests delivered; B passes through from slave to sel
module axil_mux_wr #(
    parameter int NUMBER_MASTER = axil_pkg::NUMBER_MASTER,
    parameter int ADDR_WIDTH    = axil_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH    = axil_pkg::DATA_WIDTH
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [NUMBER_MASTER-1:0]               grant_wr,

    input  logic [NUMBER_MASTER*ADDR_WIDTH-1:0]    m_axil_awaddr,
    input  logic [NUMBER_MASTER*3-1:0]             m_axil_awprot,
    input  logic [NUMBER_MASTER-1:0]               m_axil_awvalid,
    output logic [NUMBER_MASTER-1:0]               m_axil_awready,
    input  logic [NUMBER_MASTER*DATA_WIDTH-1:0]    m_axil_wdata,
    input  logic [NUMBER_MASTER*DATA_WIDTH/8-1:0]  m_axil_wstrb,
    input  logic [NUMBER_MASTER-1:0]               m_axil_wvalid,
    output logic [NUMBER_MASTER-1:0]               m_axil_wready,
    output logic [1:0]                             m_axil_bresp,
    output logic [NUMBER_MASTER-1:0]               m_axil_bvalid,
    input  logic [NUMBER_MASTER-1:0]               m_axil_bready,

    output logic [ADDR_WIDTH-1:0]                  s_axil_awaddr,
    output logic [2:0]                             s_axil_awprot,
    output logic                                   s_axil_awvalid,
    input  logic                                   s_axil_awready,
    output logic [DATA_WIDTH-1:0]                  s_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]                s_axil_wstrb,
    output logic                                   s_axil_wvalid,
    input  logic                                   s_axil_wready,
    input  logic [1:0]                             s_axil_bresp,
    input  logic                                   s_axil_bvalid,
    output logic                                   s_axil_bready
);

    localparam int SEL_W  = $clog2(NUMBER_MASTER);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AW_W   = ADDR_WIDTH + 3;
    localparam int W_W    = DATA_WIDTH + STRB_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state;
    logic [SEL_W-1:0]         sel;
    logic [SEL_W-1:0]         grant_idx;
    logic [NUMBER_MASTER-1:0] sel_onehot;
    logic                     aw_done;
    logic                     w_done;
    logic                     aw_full;
    logic                     w_full;
    logic                     aw_rdy;
    logic                     w_rdy;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     xfer_done;
    logic                     b_hs;
    logic [AW_W-1:0]          aw_in;
    logic [AW_W-1:0]          aw_q;
    logic [W_W-1:0]           w_in;
    logic [W_W-1:0]           w_q;

    // Lowest set bit wins if the arbiter ever hands over a non-one-hot grant.
    always_comb begin
        grant_idx = '0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            if (grant_wr[i]) begin
                grant_idx = SEL_W'(i);
            end
        end
    end

    assign sel_onehot = NUMBER_MASTER'(1) << sel;

    // Each channel is accepted once per transaction and never while its
    // buffer is still waiting on the slave.
    assign aw_rdy = (state == XFER) && !aw_done && !aw_full;
    assign w_rdy  = (state == XFER) && !w_done && !w_full;
    assign aw_hs  = aw_rdy && m_axil_awvalid[sel];
    assign w_hs   = w_rdy && m_axil_wvalid[sel];

    assign aw_in = {m_axil_awprot[int'(sel)*3 +: 3],
                    m_axil_awaddr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH]};
    assign w_in  = {m_axil_wstrb[int'(sel)*STRB_W +: STRB_W],
                    m_axil_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH]};

    // Leave XFER on the same edge the last buffer drains so RESP is entered
    // without an extra idle cycle.
    assign xfer_done = aw_done && w_done
                       && (!aw_full || s_axil_awready)
                       && (!w_full || s_axil_wready);

    // Same condition the arbiter uses to release its grant.
    assign b_hs = (state == RESP) && s_axil_bvalid && m_axil_bready[sel];

    axil_chan_buf #(.WIDTH(AW_W)) u_aw_buf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (aw_hs),
        .data_in (aw_in),
        .drain   (s_axil_awready),
        .full    (aw_full),
        .data    (aw_q)
    );

    axil_chan_buf #(.WIDTH(W_W)) u_w_buf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (w_hs),
        .data_in (w_in),
        .drain   (s_axil_wready),
        .full    (w_full),
        .data    (w_q)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            sel     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant_wr) begin
                        sel     <= grant_idx;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (xfer_done) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axil_awready = aw_rdy ? sel_onehot : '0;
    assign m_axil_wready  = w_rdy ? sel_onehot : '0;

    assign s_axil_awvalid               = aw_full;
    assign {s_axil_awprot, s_axil_awaddr} = aw_q;
    assign s_axil_wvalid                = w_full;
    assign {s_axil_wstrb, s_axil_wdata}   = w_q;

    assign m_axil_bresp  = s_axil_bresp;
    assign m_axil_bvalid = ((state == RESP) && s_axil_bvalid) ? sel_onehot : '0;
    assign s_axil_bready = (state == RESP) && m_axil_bready[sel];

endmodule

// File: tb/tb_axil_mux_wr.sv
module tb_axil_mux_wr;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [NM-1:0]  grant_wr = '0;
    logic [NM*AW-1:0]   m_axil_awaddr = '0;
    logic [NM*3-1:0]    m_axil_awprot = '0;
    logic [NM-1:0]      m_axil_awvalid = '0;
    logic [NM-1:0]      m_axil_awready;
    logic [NM*DW-1:0]   m_axil_wdata = '0;
    logic [NM*DW/8-1:0] m_axil_wstrb = '0;
    logic [NM-1:0]      m_axil_wvalid = '0;
    logic [NM-1:0]      m_axil_wready;
    logic [1:0]         m_axil_bresp;
    logic [NM-1:0]      m_axil_bvalid;
    logic [NM-1:0]      m_axil_bready = '0;
    logic [AW-1:0]      s_axil_awaddr;
    logic [2:0]         s_axil_awprot;
    logic               s_axil_awvalid;
    logic               s_axil_awready = 1'b0;
    logic [DW-1:0]      s_axil_wdata;
    logic [DW/8-1:0]    s_axil_wstrb;
    logic               s_axil_wvalid;
    logic               s_axil_wready = 1'b0;
    logic [1:0]         s_axil_bresp = '0;
    logic               s_axil_bvalid = 1'b0;
    logic               s_axil_bready;

    int n_tests = 0;
    int n_fail  = 0;

    axil_mux_wr #(.NUMBER_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn), .grant_wr(grant_wr),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]  grant;
        int          exp_idx;
        int          aw_dly;
        int          w_dly;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_stall;
        int          w_stall;
        int          b_stall;
        logic [1:0]  bresp;
        bit          b_early;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_awready"}, 64'(m_axil_awready), 64'd0);
        check({tag, "_idle_wready"},  64'(m_axil_wready), 64'd0);
        check({tag, "_idle_bvalid"},  64'(m_axil_bvalid), 64'd0);
        check({tag, "_idle_bready"},  64'(s_axil_bready), 64'd0);
        check({tag, "_idle_svalid"},  64'({s_axil_awvalid, s_axil_wvalid}), 64'd0);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_txn(input vec_t v, input string tag);
        int s = v.exp_idx;
        int o = 1 - v.exp_idx;
        int t = 0;
        int n_maw = 0, n_mw = 0, n_saw = 0, n_sw = 0, n_b = 0;
        int maw_neg = -1, mw_neg = -1, saw_neg = -1, sw_neg = -1;
        int aw_seen = 0, w_seen = 0, bv_cyc = 0;
        bit leak = 0, unstable = 0, early_b = 0, bresp_bad = 0, done = 0, rdy_full = 0;
        bit aw_wait = 0, w_wait = 0;
        logic [34:0] prev_aw = '0;
        logic [35:0] prev_w = '0;
        logic [31:0] cap_addr = '0, cap_data = '0;
        logic [2:0]  cap_prot = '0;
        logic [3:0]  cap_strb = '0;

        grant_wr = v.grant;
        m_axil_awaddr[s*AW +: AW] = v.addr;
        m_axil_awprot[s*3 +: 3]   = v.prot;
        m_axil_wdata[s*DW +: DW]  = v.data;
        m_axil_wstrb[s*4 +: 4]    = v.strb;
        m_axil_awaddr[o*AW +: AW] = 32'hBAD0_0BAD;
        m_axil_awprot[o*3 +: 3]   = 3'b111;
        m_axil_wdata[o*DW +: DW]  = 32'h0BAD_BAD0;
        m_axil_wstrb[o*4 +: 4]    = 4'b0101;
        m_axil_awvalid[o] = 1'b1;
        m_axil_wvalid[o]  = 1'b1;
        m_axil_bready[o]  = 1'b1;
        m_axil_awvalid[s] = (v.aw_dly == 0);
        m_axil_wvalid[s]  = (v.w_dly == 0);
        m_axil_bready[s]  = (v.b_stall == 0);
        s_axil_awready = (v.aw_stall == 0);
        s_axil_wready  = (v.w_stall == 0);
        s_axil_bvalid  = v.b_early;
        s_axil_bresp   = v.bresp;

        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge aclk);
            if (s_axil_bready && (n_saw == 0 || n_sw == 0)) early_b = 1;
            if (m_axil_awready[o] || m_axil_wready[o] || m_axil_bvalid[o]) leak = 1;
            if ((s_axil_awvalid && m_axil_awready[s]) || (s_axil_wvalid && m_axil_wready[s])) rdy_full = 1;
            if (aw_wait && (!s_axil_awvalid || {s_axil_awprot, s_axil_awaddr} != prev_aw)) unstable = 1;
            if (w_wait && (!s_axil_wvalid || {s_axil_wstrb, s_axil_wdata} != prev_w)) unstable = 1;
            aw_wait = s_axil_awvalid && !s_axil_awready;
            w_wait  = s_axil_wvalid && !s_axil_wready;
            prev_aw = {s_axil_awprot, s_axil_awaddr};
            prev_w  = {s_axil_wstrb, s_axil_wdata};
            if (m_axil_awvalid[s] && m_axil_awready[s]) begin n_maw++; maw_neg = t; end
            if (m_axil_wvalid[s] && m_axil_wready[s]) begin n_mw++; mw_neg = t; end
            if (s_axil_awvalid) begin
                if (saw_neg < 0) saw_neg = t;
                aw_seen++;
                if (s_axil_awready) begin
                    n_saw++; cap_addr = s_axil_awaddr; cap_prot = s_axil_awprot;
                end
            end
            if (s_axil_wvalid) begin
                if (sw_neg < 0) sw_neg = t;
                w_seen++;
                if (s_axil_wready) begin
                    n_sw++; cap_data = s_axil_wdata; cap_strb = s_axil_wstrb;
                end
            end
            if (m_axil_bvalid[s]) begin
                bv_cyc++;
                if (m_axil_bresp != v.bresp) bresp_bad = 1;
                if (m_axil_bready[s] && s_axil_bready) begin n_b++; done = 1; end
            end
            @(posedge aclk); #1;
            t++;
            if (done) begin
                grant_wr = '0;
                m_axil_awvalid = '0;
                m_axil_wvalid = '0;
                m_axil_bready = '0;
                s_axil_bvalid = 1'b0;
            end else begin
                m_axil_awvalid[s] = (t >= v.aw_dly) && (n_maw == 0);
                m_axil_wvalid[s]  = (t >= v.w_dly) && (n_mw == 0);
                s_axil_awready = (aw_seen >= v.aw_stall);
                s_axil_wready  = (w_seen >= v.w_stall);
                s_axil_bvalid  = v.b_early || (n_saw > 0 && n_sw > 0);
                m_axil_bready[s] = (bv_cyc >= v.b_stall);
            end
        end

        check({tag, "_completed"}, 64'(done), 64'd1);
        check({tag, "_m_aw_count"}, 64'(n_maw), 64'd1);
        check({tag, "_m_w_count"}, 64'(n_mw), 64'd1);
        check({tag, "_s_aw_count"}, 64'(n_saw), 64'd1);
        check({tag, "_s_w_count"}, 64'(n_sw), 64'd1);
        check({tag, "_b_count"}, 64'(n_b), 64'd1);
        check({tag, "_awaddr"}, 64'(cap_addr), 64'(v.addr));
        check({tag, "_awprot"}, 64'(cap_prot), 64'(v.prot));
        check({tag, "_wdata"}, 64'(cap_data), 64'(v.data));
        check({tag, "_wstrb"}, 64'(cap_strb), 64'(v.strb));
        check({tag, "_aw_latency"}, 64'(saw_neg - maw_neg), 64'd1);
        check({tag, "_w_latency"}, 64'(sw_neg - mw_neg), 64'd1);
        check({tag, "_bvalid_cycles"}, 64'(bv_cyc), 64'(v.b_stall + 1));
        check({tag, "_bresp_bad"}, 64'(bresp_bad), 64'd0);
        check({tag, "_other_master_leak"}, 64'(leak), 64'd0);
        check({tag, "_slave_unstable"}, 64'(unstable), 64'd0);
        check({tag, "_ready_while_full"}, 64'(rdy_full), 64'd0);
        check({tag, "_early_bready"}, 64'(early_b), 64'd0);
        @(negedge aclk);
        check_idle(tag);
        @(posedge aclk); #1;
    endtask

    initial begin
        //          grant  idx aw  w  addr          prot    data          strb    aws ws bs bresp  early
        vecs[0] = '{2'b01, 0, 0, 0, 32'h0000_1000, 3'b000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0};
        vecs[1] = '{2'b10, 1, 4, 0, 32'h0000_2004, 3'b010, 32'h1234_5678, 4'h3, 0, 0, 0, 2'b00, 1'b0};
        vecs[2] = '{2'b01, 0, 0, 1, 32'h0000_3000, 3'b001, 32'hCAFE_F00D, 4'hC, 5, 0, 0, 2'b00, 1'b0};
        vecs[3] = '{2'b10, 1, 0, 0, 32'h0000_4000, 3'b111, 32'hA5A5_A5A5, 4'hF, 0, 2, 4, 2'b10, 1'b0};
        vecs[4] = '{2'b11, 0, 2, 1, 32'h0000_5008, 3'b100, 32'h0F0F_0F0F, 4'h1, 1, 1, 1, 2'b01, 1'b0};
        vecs[5] = '{2'b01, 0, 1, 3, 32'hFFFF_FFFC, 3'b011, 32'h8000_0001, 4'h8, 0, 0, 2, 2'b11, 1'b1};

        // Reset state
        #12;
        check("rst_s_awvalid", 64'(s_axil_awvalid), 64'd0);
        check("rst_s_wvalid", 64'(s_axil_wvalid), 64'd0);
        check("rst_s_awaddr", 64'(s_axil_awaddr), 64'd0);
        check("rst_s_wdata", 64'(s_axil_wdata), 64'd0);
        check("rst_m_readies", 64'({m_axil_awready, m_axil_wready}), 64'd0);
        check("rst_b_valid_ready", 64'({m_axil_bvalid, s_axil_bready}), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of XFER while the AW buffer is full
        grant_wr = 2'b01;
        m_axil_awaddr[0 +: AW] = 32'h0000_6000;
        m_axil_awvalid = 2'b01;
        m_axil_wvalid = '0;
        s_axil_awready = 1'b0;
        begin
            bit seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge aclk);
                if (m_axil_awready[0]) begin
                    @(posedge aclk); #1;
                    m_axil_awvalid = '0;
                    @(negedge aclk);
                end
                seen = s_axil_awvalid;
            end
            check("mid_rst_pre_awvalid", 64'(seen), 64'd1);
        end
        check("mid_rst_pre_awaddr", 64'(s_axil_awaddr), 64'h6000);
        check("mid_rst_awready_full", 64'(m_axil_awready), 64'd0);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_async_awvalid", 64'(s_axil_awvalid), 64'd0);
        check("mid_rst_async_awaddr", 64'(s_axil_awaddr), 64'd0);
        grant_wr = '0;
        m_axil_awvalid = '0;
        m_axil_wvalid = '0;
        m_axil_bready = '0;
        s_axil_awready = 1'b0;
        s_axil_wready = 1'b0;
        s_axil_bvalid = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check_idle("post_rst");
        @(posedge aclk); #1;
        do_txn(vecs[0], "post_rst_txn");
        do_txn(vecs[3], "post_rst_txn2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
